eh2_bht_update_writer: RTL and testbench
========================================

// Module: eh2_bht_update_writer
// PURPOSE
//  Write side of the GHR-hashed BHT. Takes resolved-branch updates from commit, forms the
//  BHT index with the same pc-hash ^ GHR fold the fetch lookup uses, queues the updates,
//  and drains them into the single-port BHT array.
//  Drains stall when fetch owns the port; forced writes resolve starvation.
// PARAMETERS
//  DEPTH        4   update queue entries (power of 2, >=2)
//  ADDR_W       8   BHT index width
//  GHR_SIZE     8   global history bits (GHR_SIZE <= ADDR_W)
//  STARVE_LIM   7   consecutive blocked cycles before a forced write
// PORTS
//  clk            in   1         core clock
//  rst            in   1         asynchronous, active-high reset
//  upd_valid      in   1         update offered
//  upd_ready      out  1         queue can accept (=count<DEPTH)
//  upd_pc_hash    in   ADDR_W    hashed PC index bits of the branch
//  upd_ghr        in   GHR_SIZE  GHR at prediction time
//  upd_taken      in   1         resolved direction
//  upd_ctr        in   2         2-bit counter read at prediction
//  bht_rd_valid   in   1         fetch lookup using the array this cycle
//  bht_rd_index   in   ADDR_W    fetch lookup index
//  bht_wr_en      out  1         array write strobe
//  bht_wr_index   out  ADDR_W    array write index
//  bht_wr_data    out  2         new counter value
//  wr_force       out  1         forced write overrides lookup; fetch must replay
//  bypass_hit     out  1         pending write matches bht_rd_index (EH2_BHT_UPD_BYPASS_EN)
//  bypass_ctr     out  2         counter value of the youngest match (EH2_BHT_UPD_BYPASS_EN)
//  q_count        out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  - Reset: queue empty, state IDLE, starve_cnt=0, all outputs 0, except upd_ready=1.
//  - Enqueue: on upd_valid&upd_ready.
//    Stores idx = upd_pc_hash ^ {{ADDR_W-GHR_SIZE{1'b0}},upd_ghr}.
//    Stores nctr = taken ? sat_inc(upd_ctr) : sat_dec(upd_ctr); saturation at 3 and 0.
//    Counter math is done at enqueue; the stored upd_ctr is used even if stale.
//    Same-index entries write in order; the last one wins.
//  - upd_valid while !upd_ready: not accepted; the producer holds.
//  - Push and pop in the same cycle: allowed at any count below DEPTH; the count is unchanged.
//    Full: upd_ready=0 the same cycle count reaches DEPTH (combinational from count).
//  - FSM:
//    IDLE: entered when the queue is empty. bht_wr_en=0.
//      -> DRAIN when count becomes non-zero.
//    DRAIN: if !bht_rd_valid, writes the head with bht_wr_en=1 (combinational, 0-cycle from
//      the state); the head pops the same cycle and starve_cnt clears.
//      Otherwise starve_cnt increments.
//      -> FORCE when starve_cnt==STARVE_LIM-1 and still blocked.
//      -> IDLE when the last entry pops with no push.
//    FORCE: writes the head with bht_wr_en=1 and wr_force=1, regardless of bht_rd_valid.
//      Pops, clears starve_cnt, then -> DRAIN (or IDLE if empty).
//  - Latency: an enqueue into an empty queue with no read conflict is written 1 cycle later.
//  - Wrap: rd/wr pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.
//  - Reset mid-drain: the queue is discarded and no write issues after reset assertion.
//    Lost updates are architecturally harmless (prediction state only).
// CONFIGURATION
//  EH2_BHT_UPD_BYPASS_EN defined:
//    - Compares bht_rd_index against the idx of every valid entry.
//    - bypass_hit=1 on any match; bypass_ctr = nctr of the youngest match.
//    - An entry writing this cycle is included.
//  EH2_BHT_UPD_BYPASS_EN undefined: bypass_hit=0 and bypass_ctr=0 constantly; no compare logic.
// STRUCTURE
//  Shared package eh2_bht_pkg:
//    - typedef bht_upd_t {idx, nctr}
//    - typedef enum bht_wr_state_e {IDLE,DRAIN,FORCE}
//    - functions sat_inc/sat_dec
//    - function bht_idx(pc_hash,ghr) for reuse by the lookup side.
//  Sub-module: eh2_bht_upd_fifo, a parameterized DEPTH x bht_upd_t FIFO exposing all
//  entries for the bypass compare. FSM and counter math stay at top level.
// TESTING
//  - Single update: pc_hash=8'h3C, ghr=8'h05, taken=1, ctr=2, no reads
//    -> next cycle wr_en=1, index=8'h39, data=3.
//  - Saturation: taken=1/ctr=3 -> data=3; taken=0/ctr=0 -> data=0; taken=0/ctr=2 -> data=1.
//  - Full: 4 pushes with bht_rd_valid=1 held -> upd_ready=0 after the 4th, q_count=4.
//    A 5th offer is held and accepted the cycle after the first pop.
//  - Starvation: 1 entry with bht_rd_valid=1 continuously -> no write for 7 cycles.
//    Cycle 8: wr_en=1, wr_force=1, queue empty, FSM IDLE.
//  - Bypass (macro on): queue idx 8'h39 with nctr=3, rd_index=8'h39 -> bypass_hit=1, ctr=3.
//    Two entries at 8'h39 (nctr 3 then 0) -> bypass_ctr=0.
//    Macro off -> bypass_hit=0.
//  - Reset with 3 entries queued -> no wr_en after rst=1; q_count=0, upd_ready=1.

Source files
------------

// File: rtl/eh2_bht_update_writer_pkg.sv
// Shared BHT types and helpers used by the BHT update writer and the fetch-side lookup.
// The index hash bht_idx() must stay identical on both sides or updates land in the wrong entry.
package eh2_bht_pkg;

  localparam int BHT_ADDR_W   = 8;
  localparam int BHT_GHR_SIZE = 8;

  typedef struct packed {
    logic [BHT_ADDR_W-1:0] idx;
    logic [1:0]            nctr;
  } bht_upd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } bht_wr_state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
  endfunction

  // GHR is zero-extended into the low index bits before the fold.
  function automatic logic [BHT_ADDR_W-1:0] bht_idx(input logic [BHT_ADDR_W-1:0]   pc_hash,
                                                    input logic [BHT_GHR_SIZE-1:0] ghr);
    logic [BHT_ADDR_W-1:0] ghr_ext;
    ghr_ext                   = '0;
    ghr_ext[BHT_GHR_SIZE-1:0] = ghr;
    return pc_hash ^ ghr_ext;
  endfunction

endpackage

// File: rtl/eh2_bht_update_writer_if.sv
// Update-in / array-write bundle between the commit-side producer (master) and the BHT writer (slave).
interface eh2_bht_update_writer_if #(
  parameter int ADDR_W   = 8,
  parameter int GHR_SIZE = 8
);
  logic                upd_valid;
  logic                upd_ready;
  logic [ADDR_W-1:0]   upd_pc_hash;
  logic [GHR_SIZE-1:0] upd_ghr;
  logic                upd_taken;
  logic [1:0]          upd_ctr;

  logic                bht_rd_valid;
  logic [ADDR_W-1:0]   bht_rd_index;

  logic                bht_wr_en;
  logic [ADDR_W-1:0]   bht_wr_index;
  logic [1:0]          bht_wr_data;
  logic                wr_force;

  logic                bypass_hit;
  logic [1:0]          bypass_ctr;

  modport master (
    output upd_valid, upd_pc_hash, upd_ghr, upd_taken, upd_ctr,
    output bht_rd_valid, bht_rd_index,
    input  upd_ready, bht_wr_en, bht_wr_index, bht_wr_data, wr_force,
    input  bypass_hit, bypass_ctr
  );

  modport slave (
    input  upd_valid, upd_pc_hash, upd_ghr, upd_taken, upd_ctr,
    input  bht_rd_valid, bht_rd_index,
    output upd_ready, bht_wr_en, bht_wr_index, bht_wr_data, wr_force,
    output bypass_hit, bypass_ctr
  );
endinterface

// File: rtl/eh2_bht_upd_fifo.sv
// DEPTH-entry FIFO of pending BHT updates. With EH2_BHT_UPD_BYPASS_EN defined it also exposes
// every entry in age order (index 0 = head/oldest) for the fetch bypass compare.
module eh2_bht_upd_fifo
  import eh2_bht_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  bht_upd_t         push_data,
  input  logic             pop,
  output bht_upd_t         head,
  output logic [CNT_W-1:0] count
`ifdef EH2_BHT_UPD_BYPASS_EN
  ,
  output bht_upd_t         entry_ord [DEPTH],
  output logic [DEPTH-1:0] valid_ord
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  bht_upd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the low bits coincide.
  assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                 (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = CNT_W'(wr_ptr_reg - rd_ptr_reg);
  assign head    = mem[rd_ptr_reg[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[IDX_W-1:0]] <= push_data;
    end
  end

`ifdef EH2_BHT_UPD_BYPASS_EN
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
    logic [IDX_W-1:0] slot;
    assign slot          = rd_ptr_reg[IDX_W-1:0] + IDX_W'(gi);
    assign entry_ord[gi] = mem[slot];
    assign valid_ord[gi] = (count > CNT_W'(gi));
  end
`endif

endmodule

// File: rtl/eh2_bht_update_writer.sv
// BHT write side: hashes committed branch updates, queues them and drains them into the
// single-port BHT, forcing a write after STARVE_LIM blocked cycles. Option: EH2_BHT_UPD_BYPASS_EN.
module eh2_bht_update_writer
  import eh2_bht_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int ADDR_W     = BHT_ADDR_W,
  parameter  int GHR_SIZE   = BHT_GHR_SIZE,
  parameter  int STARVE_LIM = 7,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  eh2_bht_update_writer_if.slave    bus,
  output logic [CNT_W-1:0]          q_count
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);

  bht_wr_state_e    state_reg;
  bht_wr_state_e    state_next;
  logic [SC_W-1:0]  starve_cnt_reg;
  logic [SC_W-1:0]  starve_cnt_next;

  logic             push;
  logic             pop;
  logic             force_wr;
  logic             has_entry;
  logic             last_pop;
  bht_upd_t         push_data;
  bht_upd_t         head;
  logic [CNT_W-1:0] count;

  assign bus.upd_ready = (count < CNT_W'(DEPTH));
  assign push          = bus.upd_valid & bus.upd_ready;

  // Counter update is computed from the prediction-time counter, even if it is stale by now.
  assign push_data = '{idx:  bht_idx(bus.upd_pc_hash, bus.upd_ghr),
                       nctr: bus.upd_taken ? sat_inc(bus.upd_ctr) : sat_dec(bus.upd_ctr)};

  assign has_entry = (count != '0);
  assign last_pop  = (count == CNT_W'(1)) && !push;

`ifdef EH2_BHT_UPD_BYPASS_EN
  bht_upd_t         entry_ord [DEPTH];
  logic [DEPTH-1:0] valid_ord;
  logic [DEPTH-1:0] match;
  logic [1:0]       byp_ctr;

  eh2_bht_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .entry_ord (entry_ord),
    .valid_ord (valid_ord)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_ord[gi] && (entry_ord[gi].idx == bus.bht_rd_index);
  end

  // Entries are in age order, so the last hit in the scan is the youngest.
  always_comb begin
    byp_ctr = 2'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        byp_ctr = entry_ord[k].nctr;
      end
    end
  end

  assign bus.bypass_hit = |match;
  assign bus.bypass_ctr = byp_ctr;
`else
  eh2_bht_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.bypass_hit = 1'b0;
  assign bus.bypass_ctr = 2'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    pop             = 1'b0;
    force_wr        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (push || has_entry) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!has_entry) begin
          state_next = IDLE;
        end else if (!bus.bht_rd_valid) begin
          pop             = 1'b1;
          starve_cnt_next = '0;
          if (last_pop) begin
            state_next = IDLE;
          end
        end else begin
          starve_cnt_next = starve_cnt_reg + SC_W'(1);
          if (starve_cnt_reg == SC_W'(STARVE_LIM - 1)) begin
            state_next = FORCE;
          end
        end
      end
      FORCE: begin
        pop             = has_entry;
        force_wr        = has_entry;
        starve_cnt_next = '0;
        state_next      = (last_pop || !has_entry) ? IDLE : DRAIN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write fields are zeroed when idle so the port never shows uninitialised queue contents.
  assign bus.bht_wr_en    = pop;
  assign bus.bht_wr_index = pop ? head.idx : '0;
  assign bus.bht_wr_data  = pop ? head.nctr : 2'd0;
  assign bus.wr_force     = force_wr;
  assign q_count          = count;

endmodule

// File: tb/tb_eh2_bht_update_writer.sv
// Scoreboard bench for eh2_bht_update_writer: expected writes are queued at enqueue and
// compared in order as the DUT writes the array.
module tb_eh2_bht_update_writer;
  import eh2_bht_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] q_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] sb_q [$];
  logic [9:0] mon_e;

`ifdef EH2_BHT_UPD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  eh2_bht_update_writer_if #(.ADDR_W(8), .GHR_SIZE(8)) bus ();

  eh2_bht_update_writer #(
    .DEPTH      (4),
    .ADDR_W     (8),
    .GHR_SIZE   (8),
    .STARVE_LIM (7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] exp_entry(input logic [7:0] pc, input logic [7:0] ghr,
                                           input logic taken, input logic [1:0] ctr);
    logic [1:0] n;
    if (taken) n = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    else       n = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    return {pc ^ ghr, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one update and hold it until accepted; returns at +1 of the cycle after acceptance.
  task automatic offer(input logic [7:0] pc, input logic [7:0] ghr,
                       input logic taken, input logic [1:0] ctr);
    bus.upd_valid   = 1'b1;
    bus.upd_pc_hash = pc;
    bus.upd_ghr     = ghr;
    bus.upd_taken   = taken;
    bus.upd_ctr     = ctr;
    for (int i = 0; i < 64; i++) begin
      #2;
      if (bus.upd_ready) begin
        sb_q.push_back(exp_entry(pc, ghr, taken, ctr));
        tick();
        bus.upd_valid = 1'b0;
        return;
      end
      tick();
    end
    check("offer_timeout", {31'b0, bus.upd_ready}, 32'd1);
    bus.upd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (q_count == 3'd0 && sb_q.size() == 0) break;
      tick();
    end
    check("drain_qcount", 32'(q_count), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // One line per array write; compared in order against the scoreboard.
  always @(negedge clk) begin
    if (bus.bht_wr_en === 1'b1) begin
      $display("wr idx=%02h data=%0d force=%0b q=%0d", bus.bht_wr_index, bus.bht_wr_data,
               bus.wr_force, q_count);
      if (sb_q.size() == 0) begin
        check("wr_unexpected", {31'b0, bus.bht_wr_en}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_idx", 32'(bus.bht_wr_index), 32'(mon_e[9:2]));
        check("wr_data", 32'(bus.bht_wr_data), 32'(mon_e[1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop_i;
    int acc_i;
    logic force_seen;

    bus.upd_valid    = 1'b0;
    bus.upd_pc_hash  = '0;
    bus.upd_ghr      = '0;
    bus.upd_taken    = 1'b0;
    bus.upd_ctr      = '0;
    bus.bht_rd_valid = 1'b0;
    bus.bht_rd_index = '0;

    // Reset state
    tick();
    tick();
    #2;
    check("rst_qcount", 32'(q_count), 32'd0);
    check("rst_ready", {31'b0, bus.upd_ready}, 32'd1);
    check("rst_wr_en", {31'b0, bus.bht_wr_en}, 32'd0);
    check("rst_wr_force", {31'b0, bus.wr_force}, 32'd0);
    check("rst_wr_index", 32'(bus.bht_wr_index), 32'd0);
    check("rst_bypass_hit", {31'b0, bus.bypass_hit}, 32'd0);
    check("rst_bypass_ctr", 32'(bus.bypass_ctr), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single update, one-cycle write latency
    offer(8'h3C, 8'h05, 1'b1, 2'd2);
    #2;
    check("single_wr_en", {31'b0, bus.bht_wr_en}, 32'd1);
    check("single_wr_index", 32'(bus.bht_wr_index), 32'h39);
    check("single_wr_data", 32'(bus.bht_wr_data), 32'd3);
    check("single_wr_force", {31'b0, bus.wr_force}, 32'd0);
    tick();
    #2;
    check("single_after_wr_en", {31'b0, bus.bht_wr_en}, 32'd0);
    check("single_after_qcount", 32'(q_count), 32'd0);
    tick();

    // Saturation at both ends plus a plain decrement
    offer(8'h10, 8'h00, 1'b1, 2'd3);
    offer(8'h20, 8'h00, 1'b0, 2'd0);
    offer(8'h30, 8'h01, 1'b0, 2'd2);
    wait_drain();

    // Full queue; fifth offer held until the first (forced) pop
    bus.bht_rd_valid = 1'b1;
    offer(8'hA0, 8'h00, 1'b1, 2'd0);
    offer(8'hA1, 8'h00, 1'b1, 2'd1);
    offer(8'hA2, 8'h00, 1'b0, 2'd3);
    offer(8'hA3, 8'h00, 1'b0, 2'd1);
    #2;
    check("full_ready", {31'b0, bus.upd_ready}, 32'd0);
    check("full_qcount", 32'(q_count), 32'd4);
    check("full_blocked_wr_en", {31'b0, bus.bht_wr_en}, 32'd0);
    tick();
    bus.upd_valid   = 1'b1;
    bus.upd_pc_hash = 8'hA4;
    bus.upd_ghr     = 8'h00;
    bus.upd_taken   = 1'b1;
    bus.upd_ctr     = 2'd2;
    pop_i = -1;
    acc_i = -2;
    force_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (bus.bht_wr_en && pop_i < 0) begin
        pop_i = i;
        force_seen = bus.wr_force;
      end
      if (bus.upd_ready) begin
        acc_i = i;
        sb_q.push_back(exp_entry(8'hA4, 8'h00, 1'b1, 2'd2));
        tick();
        break;
      end
      tick();
    end
    bus.upd_valid    = 1'b0;
    bus.bht_rd_valid = 1'b0;
    check("full_accept_after_pop", 32'(acc_i), 32'(pop_i + 1));
    check("full_pop_forced", {31'b0, force_seen}, 32'd1);
    wait_drain();

    // Starvation: seven blocked cycles, then a forced write on the eighth
    bus.bht_rd_valid = 1'b1;
    offer(8'h55, 8'h0F, 1'b1, 2'd1);
    for (int i = 1; i <= 7; i++) begin
      #2;
      check("starve_no_wr", {31'b0, bus.bht_wr_en}, 32'd0);
      tick();
    end
    #2;
    check("starve_force_wr_en", {31'b0, bus.bht_wr_en}, 32'd1);
    check("starve_force_flag", {31'b0, bus.wr_force}, 32'd1);
    tick();
    #2;
    check("starve_qcount", 32'(q_count), 32'd0);
    check("starve_state_idle", 32'(dut.state_reg), 32'(IDLE));
    check("starve_after_wr_en", {31'b0, bus.bht_wr_en}, 32'd0);
    bus.bht_rd_valid = 1'b0;
    tick();

    // Bypass: youngest match wins
    bus.bht_rd_valid = 1'b1;
    bus.bht_rd_index = 8'h39;
    offer(8'h3C, 8'h05, 1'b1, 2'd2);
    #2;
    check("byp_hit_one", {31'b0, bus.bypass_hit}, {31'b0, BYP});
    check("byp_ctr_one", 32'(bus.bypass_ctr), BYP ? 32'd3 : 32'd0);
    tick();
    offer(8'h39, 8'h00, 1'b0, 2'd1);
    #2;
    check("byp_hit_two", {31'b0, bus.bypass_hit}, {31'b0, BYP});
    check("byp_ctr_youngest", 32'(bus.bypass_ctr), 32'd0);
    bus.bht_rd_index = 8'h40;
    #1;
    check("byp_miss", {31'b0, bus.bypass_hit}, 32'd0);
    bus.bht_rd_valid = 1'b0;
    tick();
    wait_drain();

    // Reset with three queued entries: queue discarded, no write after assertion
    bus.bht_rd_valid = 1'b1;
    offer(8'h61, 8'h00, 1'b1, 2'd0);
    offer(8'h62, 8'h00, 1'b1, 2'd1);
    offer(8'h63, 8'h00, 1'b0, 2'd2);
    #0;
    check("pre_rst_qcount", 32'(q_count), 32'd3);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("midrst_wr_en", {31'b0, bus.bht_wr_en}, 32'd0);
    check("midrst_qcount", 32'(q_count), 32'd0);
    check("midrst_ready", {31'b0, bus.upd_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    bus.bht_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("post_rst_wr_en", {31'b0, bus.bht_wr_en}, 32'd0);
      tick();
    end

    // Mixed traffic over a few indices; same-index writes must stay in order
    for (int i = 0; i < 12; i++) begin
      bus.bht_rd_valid = 1'($urandom_range(0, 1));
      offer(8'($urandom_range(0, 3)), 8'h00, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    bus.bht_rd_valid = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
